fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   IF stage of the 5-stage RISC pipeline: owns the PC, drives the combinational instruction
//   memory (word-addressed via addr[31:2]), and captures the returned word into the IF/ID
//   register for decode. Applies hazard-unit stalls and later-stage redirects (J/CLL/JR/taken
//   branch; static predict-not-taken). Halts on the 0xFFFFFFFF fill word.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC loaded on reset
//   NOP_INSTR  32'h0000_0000  instr placed in IF/ID for a bubble
//   HALT_WORD  32'hFFFF_FFFF  word that stops fetch (unprogrammed imem fill)
//   CNT_W      16             width of fetch_count
// PORTS
//   clk             in   1      rising-edge clock
//   rst_n           in   1      asynchronous active-low reset
//   imem_addr       out  32     byte address to instruction memory (= pc_q, bits[1:0] = 0)
//   imem_instr      in   32     instruction word returned combinationally for imem_addr
//   stall           in   1      hazard unit: hold PC and IF/ID (load-use, LDW/SDW 2nd round)
//   redir_valid     in   1      later stage resolved a control transfer this cycle
//   redir_target    in   32     byte target of redirect; bits[1:0] ignored (forced 0)
//   if_id_valid     out  1      IF/ID holds a real instruction
//   if_id_instr     out  32     opcode[31:26] Rd[25:22] Rs[21:18] Rt[17:14] Imm[13:0]
//   if_id_pc        out  32     address of if_id_instr
//   if_id_pc_plus4  out  32     if_id_pc + 4 (CLL link value for R14)
//   halted          out  1      fetch stopped on HALT_WORD
//   fetch_count     out  CNT_W  count of instructions loaded into IF/ID with valid=1
// BEHAVIOUR
//   Reset (async, rst_n=0): pc_q=RESET_PC; if_id_valid=0; if_id_instr=NOP_INSTR;
//     if_id_pc=0; if_id_pc_plus4=0; halted=0; fetch_count=0. Outputs settle without a clock edge.
//   imem_addr = {pc_q[31:2],2'b00} always; fetched word is used in the same cycle (0 latency).
//   State machine, 2 states: RUN (halted=0), HALT (halted=1). Per-edge priority:
//     1. redir_valid (either state, overrides stall): pc_q<={redir_target[31:2],2'b00};
//        IF/ID<=bubble; state<=RUN. The wrong-path word at imem_addr is discarded.
//     2. stall: pc_q, IF/ID, state, and fetch_count all hold.
//     3. RUN, imem_instr==HALT_WORD: pc_q holds; IF/ID<=bubble; state<=HALT.
//     4. RUN, otherwise: IF/ID<={valid=1, imem_instr, pc_q, pc_q+4}; pc_q<=pc_q+4;
//        fetch_count<=fetch_count+1.
//     5. HALT, no redirect: pc_q holds; IF/ID<=bubble every cycle.
//   Bubble = {valid=0, instr=NOP_INSTR, pc=pc_q, pc_plus4=pc_q+4}.
//   Arithmetic: pc+4 is modulo 2^32 (0xFFFF_FFFC -> 0). fetch_count wraps modulo 2^CNT_W.
//   A halt is speculative: a HALT_WORD fetched past an unresolved branch is cleared by the
//     later redirect. Decode never sees HALT_WORD as a valid instruction.
//   Redirect target arithmetic (PC + sext(Imm14)*4, or a register value for JR) is computed
//     upstream. This block only loads the value it is given.
// STRUCTURE
//   Shared package isa_pkg: field slices (OPC_MSB/LSB, RD/RS/RT/IMM positions), opcode
//     localparams (OR=0, ADD=1, SUB=2, CMP=3, ORI=4, ADDI=5, LW=6, SW=7, LDW=8, SDW=9,
//     BZ=10, BGZ=11, BLZ=12, JR=13, J=14, CLL=15), NOP_INSTR, HALT_WORD.
//   One sub-module, if_id_reg: the enable/flush pipeline register (valid, instr, pc, pc_plus4).
//     PC register, next-PC mux, and the RUN/HALT FSM stay in fetch_stage.
// TESTING (bench pairs fetch_stage with instruction_memory, loading sample program 1)
//   1 Reset/sequence: rst_n low 2 cycles, release -> imem_addr 0,4,8,...; if_id_instr after
//     1st edge = ADDI R1,R0,5 with if_id_pc=0 and pc_plus4=4; fetch_count=9 after 9 edges.
//   2 Stall: assert stall 2 cycles at pc_q=0x8 -> imem_addr stays 0x8; IF/ID keeps pc=0x4
//     instr; after release, next IF/ID = ADD R3 at pc 0x8 (no skip, no duplicate).
//   3 Redirect: redir_valid with target 0x2D (misaligned) at pc_q=0x10 -> next pc_q=0x2C;
//     if_id_valid=0 for that cycle; next cycle IF/ID holds word 11 with pc=0x2C.
//   4 Halt: run program 1 to word 9 (0xFFFFFFFF) -> halted=1; imem_addr stuck at 0x24;
//     if_id_valid=0; fetch_count frozen at 9 for 10 cycles.
//   5 Simultaneous: stall=1 and redir_valid=1 (target 0x0) while halted -> redirect wins:
//     halted=0, pc_q=0; on the next edge, IF/ID=ADDI R1 (pc 0) with stall dropped.
//   6 Reset mid-run: drop rst_n between clock edges at pc_q=0x14 -> all outputs reach reset
//     values immediately, before the next clk edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 5-stage pipeline: instruction field positions,
// opcodes, special instruction words and the IF-stage state/register types.
package isa_pkg;

    localparam int XLEN = 32;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 22;
    localparam int RS_MSB  = 21;
    localparam int RS_LSB  = 18;
    localparam int RT_MSB  = 17;
    localparam int RT_LSB  = 14;
    localparam int IMM_MSB = 13;
    localparam int IMM_LSB = 0;

    localparam logic [5:0] OPC_OR   = 6'd0;
    localparam logic [5:0] OPC_ADD  = 6'd1;
    localparam logic [5:0] OPC_SUB  = 6'd2;
    localparam logic [5:0] OPC_CMP  = 6'd3;
    localparam logic [5:0] OPC_ORI  = 6'd4;
    localparam logic [5:0] OPC_ADDI = 6'd5;
    localparam logic [5:0] OPC_LW   = 6'd6;
    localparam logic [5:0] OPC_SW   = 6'd7;
    localparam logic [5:0] OPC_LDW  = 6'd8;
    localparam logic [5:0] OPC_SDW  = 6'd9;
    localparam logic [5:0] OPC_BZ   = 6'd10;
    localparam logic [5:0] OPC_BGZ  = 6'd11;
    localparam logic [5:0] OPC_BLZ  = 6'd12;
    localparam logic [5:0] OPC_JR   = 6'd13;
    localparam logic [5:0] OPC_J    = 6'd14;
    localparam logic [5:0] OPC_CLL  = 6'd15;

    // Unprogrammed instruction memory reads back as all ones; fetch treats it as a stop.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic {
        FETCH_RUN,
        FETCH_HALT
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } if_id_t;

    function automatic logic [31:0] make_instr(input logic [5:0] opc, input logic [3:0] rd,
                                               input logic [3:0] rs, input logic [3:0] rt,
                                               input logic [13:0] imm);
        return {opc, rd, rs, rt, imm};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched instruction or a bubble when enabled,
// holds its contents otherwise.
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = isa_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] fetch_instr,
    input  logic [31:0] fetch_pc,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);
    import isa_pkg::*;

    if_id_t q;
    if_id_t d;

    // A bubble still records the current PC so decode always sees a coherent pc/pc_plus4 pair.
    always_comb begin
        d.valid    = ~flush;
        d.instr    = flush ? NOP_INSTR : fetch_instr;
        d.pc       = fetch_pc;
        d.pc_plus4 = fetch_pc + 32'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.valid    <= 1'b0;
            q.instr    <= NOP_INSTR;
            q.pc       <= 32'h0;
            q.pc_plus4 <= 32'h0;
        end else if (en) begin
            q <= d;
        end
    end

    assign valid    = q.valid;
    assign instr    = q.instr;
    assign pc       = q.pc;
    assign pc_plus4 = q.pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, reads the combinational instruction memory and feeds IF/ID.
// Redirects beat stalls; a fetched HALT_WORD parks fetch until a redirect arrives.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = isa_pkg::NOP_INSTR,
    parameter logic [31:0] HALT_WORD = isa_pkg::HALT_WORD,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_instr,
    input  logic             stall,
    input  logic             redir_valid,
    input  logic [31:0]      redir_target,
    output logic             if_id_valid,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_pc_plus4,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);
    import isa_pkg::*;

    fetch_state_e state_q;
    fetch_state_e state_d;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_inc;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        cnt_en;
    logic        halt_hit;
    logic [1:0]  unused_target_bits;

    assign unused_target_bits = redir_target[1:0];
    assign pc_inc             = pc_q + 32'd4;
    assign imem_addr          = {pc_q[31:2], 2'b00};
    assign halt_hit           = (imem_instr == HALT_WORD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redir_valid) begin
            state_d = FETCH_RUN;
        end else if (!stall && state_q == FETCH_RUN && halt_hit) begin
            state_d = FETCH_HALT;
        end
    end

    // A redirect flushes the wrong-path word even when the hazard unit asks for a stall.
    always_comb begin
        pc_en      = 1'b0;
        pc_d       = pc_q;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        cnt_en     = 1'b0;
        halted     = (state_q == FETCH_HALT);
        if (redir_valid) begin
            pc_en      = 1'b1;
            pc_d       = {redir_target[31:2], 2'b00};
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
        end else if (!stall) begin
            case (state_q)
                FETCH_RUN: begin
                    ifid_en = 1'b1;
                    if (halt_hit) begin
                        ifid_flush = 1'b1;
                    end else begin
                        pc_en  = 1'b1;
                        pc_d   = pc_inc;
                        cnt_en = 1'b1;
                    end
                end
                FETCH_HALT: begin
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                end
                default: begin
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (pc_en) begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (cnt_en) begin
            fetch_count <= fetch_count + CNT_W'(1);
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (ifid_en),
        .flush       (ifid_flush),
        .fetch_instr (imem_instr),
        .fetch_pc    (pc_q),
        .valid       (if_id_valid),
        .instr       (if_id_instr),
        .pc          (if_id_pc),
        .pc_plus4    (if_id_pc_plus4)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage driving a small program image: stimulus pushes the
// expected IF state per cycle, an independent monitor pops and compares after each edge.
module tb_fetch_stage;
    import isa_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        halted;
    logic [15:0] fetch_count;

    logic [31:0] prog [64];

    assign imem_instr = prog[imem_addr[7:2]];

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .stall          (stall),
        .redir_valid    (redir_valid),
        .redir_target   (redir_target),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] addr;
        logic        halt;
        logic [15:0] cnt;
        logic        hand_en;
        logic [31:0] hand_instr;
        logic [31:0] hand_pc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    event async_ev;

    logic [31:0] m_pc;
    logic        m_halt;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_ipc4;
    logic [15:0] m_cnt;

    function automatic void checkField(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic void checkOutput(exp_t e);
        checkField({e.name, ".valid"}, {31'h0, if_id_valid}, {31'h0, e.valid});
        checkField({e.name, ".instr"}, if_id_instr, e.instr);
        checkField({e.name, ".pc"}, if_id_pc, e.pc);
        checkField({e.name, ".pc_plus4"}, if_id_pc_plus4, e.pc4);
        checkField({e.name, ".imem_addr"}, imem_addr, e.addr);
        checkField({e.name, ".halted"}, {31'h0, halted}, {31'h0, e.halt});
        checkField({e.name, ".fetch_count"}, {16'h0, fetch_count}, {16'h0, e.cnt});
        if (e.hand_en) begin
            checkField({e.name, ".hand_instr"}, if_id_instr, e.hand_instr);
            checkField({e.name, ".hand_pc"}, if_id_pc, e.hand_pc);
        end
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or async_ev);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    function automatic void modelReset();
        m_pc    = 32'h0;
        m_halt  = 1'b0;
        m_valid = 1'b0;
        m_instr = 32'h0;
        m_ipc   = 32'h0;
        m_ipc4  = 32'h0;
        m_cnt   = 16'h0;
    endfunction

    function automatic void modelStep(logic s, logic r, logic [31:0] t);
        logic [31:0] word;
        word = prog[m_pc[7:2]];
        if (r) begin
            m_valid = 1'b0; m_instr = 32'h0; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
            m_pc = {t[31:2], 2'b00};
            m_halt = 1'b0;
        end else if (s) begin
            m_valid = m_valid;
        end else if (!m_halt && word == 32'hFFFF_FFFF) begin
            m_valid = 1'b0; m_instr = 32'h0; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
            m_halt = 1'b1;
        end else if (!m_halt) begin
            m_valid = 1'b1; m_instr = word; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
            m_pc = m_pc + 32'd4;
            m_cnt = m_cnt + 16'd1;
        end else begin
            m_valid = 1'b0; m_instr = 32'h0; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
        end
    endfunction

    function automatic void pushExpect(string name, logic hand_en, logic [31:0] hi, logic [31:0] hp);
        exp_t e;
        e.name = name; e.valid = m_valid; e.instr = m_instr; e.pc = m_ipc; e.pc4 = m_ipc4;
        e.addr = m_pc; e.halt = m_halt; e.cnt = m_cnt;
        e.hand_en = hand_en; e.hand_instr = hi; e.hand_pc = hp;
        sb.push_back(e);
    endfunction

    task automatic applyStimulus(string name, logic s, logic r, logic [31:0] t,
                                 logic hand_en = 1'b0, logic [31:0] hi = 32'h0, logic [31:0] hp = 32'h0);
        stall        = s;
        redir_valid  = r;
        redir_target = t;
        modelStep(s, r, t);
        pushExpect(name, hand_en, hi, hp);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        for (int i = 0; i < 64; i++) prog[i] = 32'hFFFF_FFFF;
        prog[0]  = 32'h1440_0005;
        prog[1]  = 32'h1480_0007;
        prog[2]  = 32'h04C4_8000;
        prog[3]  = 32'h090C_4000;
        prog[4]  = 32'h0144_8000;
        prog[5]  = 32'h0D91_4000;
        prog[6]  = 32'h1CC0_0000;
        prog[7]  = 32'h19C0_0000;
        prog[8]  = 32'h2818_0002;
        prog[10] = 32'h1200_0001;
        prog[11] = 32'h1664_0001;
        prog[63] = 32'h3C00_0010;

        rst_n = 1'b0; stall = 1'b0; redir_valid = 1'b0; redir_target = 32'h0;
        modelReset();
        @(negedge clk);
        pushExpect("reset", 1'b0, 32'h0, 32'h0);
        ->async_ev;
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("seq0", 1'b0, 1'b0, 32'h0, 1'b1, 32'h1440_0005, 32'h0);
        for (int i = 1; i < 9; i++) applyStimulus("seq", 1'b0, 1'b0, 32'h0);
        applyStimulus("halt_hit", 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) applyStimulus("halt_hold", 1'b0, 1'b0, 32'h0);

        applyStimulus("simul_redir", 1'b1, 1'b1, 32'h0);
        applyStimulus("after_simul", 1'b0, 1'b0, 32'h0, 1'b1, 32'h1440_0005, 32'h0);
        applyStimulus("to_pc8", 1'b0, 1'b0, 32'h0);
        applyStimulus("stall1", 1'b1, 1'b0, 32'h0, 1'b1, 32'h1480_0007, 32'h4);
        applyStimulus("stall2", 1'b1, 1'b0, 32'h0, 1'b1, 32'h1480_0007, 32'h4);
        applyStimulus("unstall", 1'b0, 1'b0, 32'h0, 1'b1, 32'h04C4_8000, 32'h8);
        applyStimulus("to_pc10", 1'b0, 1'b0, 32'h0);
        applyStimulus("redir_2d", 1'b0, 1'b1, 32'h0000_002D);
        applyStimulus("after_redir", 1'b0, 1'b0, 32'h0, 1'b1, 32'h1664_0001, 32'h2C);
        applyStimulus("spec_halt", 1'b0, 1'b0, 32'h0);
        applyStimulus("redir_top", 1'b0, 1'b1, 32'hFFFF_FFFE);
        applyStimulus("pc_wrap", 1'b0, 1'b0, 32'h0, 1'b1, 32'h3C00_0010, 32'hFFFF_FFFC);
        for (int i = 0; i < 5; i++) applyStimulus("to_pc14", 1'b0, 1'b0, 32'h0);

        #2;
        rst_n = 1'b0;
        modelReset();
        pushExpect("mid_reset", 1'b0, 32'h0, 32'h0);
        ->async_ev;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("restart0", 1'b0, 1'b0, 32'h0, 1'b1, 32'h1440_0005, 32'h0);
        applyStimulus("restart1", 1'b0, 1'b0, 32'h0);
        applyStimulus("restart2", 1'b0, 1'b0, 32'h0);

        @(negedge clk);
        @(negedge clk);
        checkField("scoreboard_drained", sb.size(), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
